alu_writeback: RTL and testbench
================================

ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 The block SHALL have these ports, clock and reset first, one per line (name  direction  width  meaning):
  clk  in  1  single clock; all state updates on its rising edge
  rst_n  in  1  asynchronous, active-low reset
  in_valid  in  1  ALU result presented this cycle
  in_ready  out  1  block can accept a result this cycle
  res_l  in  8  ALU low result byte
  res_h  in  8  ALU high result byte (MUL)
  carry_in, zero_in, sign_in  in  1 each  ALU flag outputs
  flag_mask  in  3  per-flag update enable {S,Z,C}
  dest  in  2  destination: 00 W, 01 W+H, 10 MEM, 11 MEM2
  mem_addr  in  8  memory destination base address
  mem_req  out  1  memory write request
  mem_addr_o  out  8  write address
  mem_wdata  out  8  write data
  mem_ack  in  1  memory accepted the write this cycle
  w_reg  out  8  working register W
  h_reg  out  8  high-result register H
  flags  out  3  status {S,Z,C}
  cpu_carry  out  1  equals flags[C]; fed back to the ALU
  wb_done  out  1  one-cycle pulse: a transaction completed
REQ-002 Clock is clk and reset is rst_n, asynchronous, active-low; no other clock exists.

Function
REQ-003 An accept SHALL occur on a rising edge where in_valid=1 and in_ready=1; in_ready=1 exactly when state is IDLE.
REQ-004 At an accept, each flag bit SHALL load its ALU input when its flag_mask bit is 1 and hold otherwise, for every dest.
REQ-005 dest=00: at the accept edge W<=res_l; H holds; state stays IDLE; wb_done=1 the following cycle.
REQ-006 dest=01: at the accept edge W<=res_l and H<=res_h together; state stays IDLE; wb_done=1 the following cycle.
REQ-007 dest=10: the accept edge latches addr=mem_addr and data=res_l and enters MEM_LO.
REQ-008 dest=11: the accept edge latches addr, res_l and res_h and enters MEM_LO.
REQ-009 In MEM_LO and MEM_HI: mem_req=1; mem_addr_o and mem_wdata come from the latched values and stay stable until the edge where mem_ack=1.
REQ-010 MEM_LO with mem_ack=1 SHALL go to IDLE when dest=10, or to MEM_HI when dest=11.
REQ-011 In MEM_HI, address = latched addr+1 modulo 256 (0xFF wraps to 0x00) and data = latched res_h.
REQ-012 MEM_HI with mem_ack=1 SHALL go to IDLE.
REQ-013 mem_ack while mem_req=0 SHALL be ignored.
REQ-014 wb_done SHALL pulse exactly one cycle after the final memory ack.
REQ-015 mem_req SHALL be 0 in IDLE; W and H are never written by memory destinations.
REQ-016 cpu_carry SHALL reflect the registered carry with no combinational path from carry_in.
REQ-017 A back-to-back accept is allowed every cycle for register destinations.

Reset
REQ-018 While rst_n=0, regardless of clock and mid-transaction, the block SHALL asynchronously force:
  state=IDLE, W=0x00, H=0x00, flags=3'b000, mem_req=0, mem_addr_o=0x00, mem_wdata=0x00, wb_done=0.
REQ-019 A pending memory write aborted by reset SHALL NOT be retried.
REQ-020 in_ready SHALL be 1 in the first cycle after reset deassertion.

Configuration
REQ-021 Macro ALU_WB_MEM_EN defined: the memory path exists as specified.
REQ-022 ALU_WB_MEM_EN undefined: dest=10/11 update flags only and complete like dest=00 without writing W; mem_req, mem_addr_o and mem_wdata are tied 0; state never leaves IDLE.

Structure
REQ-023 Shared package cpu_pkg SHALL hold:
  dest encodings
  FSM state encoding (IDLE, MEM_LO, MEM_HI)
  flag bit indices (C=0, Z=1, S=2)
REQ-024 One sub-module, alu_wb_flags, SHALL hold the masked flag register and drive cpu_carry; everything else stays in alu_writeback.

Verification
REQ-025 Reset then dest=00, res_l=0x5A, carry_in=1, mask=3'b111 -> W=0x5A, flags=3'b001, cpu_carry=1, wb_done one cycle later.
REQ-026 dest=01, res_h=0x12, res_l=0x34, mask=3'b010, zero_in=1 -> H=0x12, W=0x34, only Z set, C and S unchanged.
REQ-027 dest=11, mem_addr=0xFF, res_l=0xAA, res_h=0xBB, ack delayed 3 cycles -> writes 0xAA@0xFF then 0xBB@0x00; in_ready=0 throughout; one wb_done.
REQ-028 dest=10 with in_valid held high during MEM_LO -> second result not accepted until IDLE; mem_addr_o and mem_wdata stable until ack.
REQ-029 rst_n low in MEM_HI -> mem_req=0 immediately, all outputs at reset values, no further write.
REQ-030 Build without ALU_WB_MEM_EN, dest=10, res_l=0x77, carry_in=1 -> W unchanged, C=1, mem_req never 1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the ALU writeback stage: destinations, FSM states, flag bit positions.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

  // Writeback destination encodings
  localparam logic [1:0] DEST_W    = 2'b00;  // W only
  localparam logic [1:0] DEST_WH   = 2'b01;  // W and H (MUL result)
  localparam logic [1:0] DEST_MEM  = 2'b10;  // one memory byte
  localparam logic [1:0] DEST_MEM2 = 2'b11;  // two memory bytes, low then high

  // Writeback FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MEM_LO = 2'd1,
    MEM_HI = 2'd2
  } wb_state_t;

  // Bit positions inside the {S,Z,C} flag vector
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_S = 2;

endpackage

// File: rtl/alu_wb_flags.sv
// Masked status-flag register {S,Z,C}; also feeds the registered carry back to the ALU.
// Latency: flags update on the accept edge, visible the following cycle.
// Backpressure: none; loads whenever the parent accepts a result.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   load                           parent accepted a result this cycle
//   flag_mask                      per-flag update enable {S,Z,C}
//   carry_in, zero_in, sign_in     ALU flag outputs
//   flags                          registered {S,Z,C}
//   cpu_carry                      registered carry, no path from carry_in
module alu_wb_flags
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [2:0] flag_mask,
  input  logic       carry_in,
  input  logic       zero_in,
  input  logic       sign_in,
  output logic [2:0] flags,
  output logic       cpu_carry
);

  logic [2:0] flag_in;

  always_comb begin
    flag_in         = 3'b000;
    flag_in[FLAG_C] = carry_in;
    flag_in[FLAG_Z] = zero_in;
    flag_in[FLAG_S] = sign_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= 3'b000;
    end else if (load) begin
      // Masked bits take the new ALU value, the others keep their state
      flags <= (flag_mask & flag_in) | (~flag_mask & flags);
    end
  end

  assign cpu_carry = flags[FLAG_C];

endmodule

// File: rtl/alu_writeback.sv
// ALU result writeback: loads W/H and flags, or writes one/two bytes to memory.
// Latency: wb_done one cycle after a register accept, or one cycle after the final memory ack.
// Backpressure: in_ready low while a memory write is outstanding; mem_req held until mem_ack.
//
// Optional feature: macro ALU_WB_MEM_EN enables the memory path. Without it,
// memory destinations only update flags and complete in one cycle.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_valid / in_ready             result handshake (ready only in IDLE)
//   res_l, res_h                    ALU low/high result bytes
//   carry_in, zero_in, sign_in      ALU flags; flag_mask selects which load
//   dest, mem_addr                  destination select, memory base address
//   mem_req, mem_addr_o, mem_wdata  memory write request (held until mem_ack)
//   mem_ack                         memory accepted the write
//   w_reg, h_reg, flags, cpu_carry  architectural state
//   wb_done                         one-cycle completion pulse
module alu_writeback
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] res_l,
  input  logic [7:0] res_h,
  input  logic       carry_in,
  input  logic       zero_in,
  input  logic       sign_in,
  input  logic [2:0] flag_mask,
  input  logic [1:0] dest,
  input  logic [7:0] mem_addr,
  output logic       mem_req,
  output logic [7:0] mem_addr_o,
  output logic [7:0] mem_wdata,
  input  logic       mem_ack,
  output logic [7:0] w_reg,
  output logic [7:0] h_reg,
  output logic [2:0] flags,
  output logic       cpu_carry,
  output logic       wb_done
);

  wb_state_t state;
  logic      accept;
  logic      is_mem;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready;
  assign is_mem   = (dest == DEST_MEM) || (dest == DEST_MEM2);

  alu_wb_flags u_flags (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .flag_mask (flag_mask),
    .carry_in  (carry_in),
    .zero_in   (zero_in),
    .sign_in   (sign_in),
    .flags     (flags),
    .cpu_carry (cpu_carry)
  );

  // W and H are only ever written by register destinations
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_reg <= 8'h00;
      h_reg <= 8'h00;
    end else if (accept && !is_mem) begin
      w_reg <= res_l;
      if (dest == DEST_WH) begin
        h_reg <= res_h;
      end
    end
  end

`ifdef ALU_WB_MEM_EN
  logic       two_beat;  // second (high) byte still to be written
  logic [7:0] hi_data;

  // mem_addr_o / mem_wdata double as the latched request, so they stay
  // stable by construction until the ack edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_addr_o <= 8'h00;
      mem_wdata  <= 8'h00;
      two_beat   <= 1'b0;
      hi_data    <= 8'h00;
      wb_done    <= 1'b0;
    end else begin
      wb_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_mem) begin
              state      <= MEM_LO;
              mem_req    <= 1'b1;
              mem_addr_o <= mem_addr;
              mem_wdata  <= res_l;
              hi_data    <= res_h;
              two_beat   <= (dest == DEST_MEM2);
            end else begin
              wb_done <= 1'b1;
            end
          end
        end
        MEM_LO: begin
          if (mem_ack) begin
            if (two_beat) begin
              state      <= MEM_HI;
              mem_addr_o <= mem_addr_o + 8'd1;  // 0xFF wraps to 0x00
              mem_wdata  <= hi_data;
            end else begin
              state   <= IDLE;
              mem_req <= 1'b0;
              wb_done <= 1'b1;
            end
          end
        end
        MEM_HI: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            wb_done <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end
`else
  // No memory path: every destination completes in one cycle from IDLE
  assign state      = IDLE;
  assign mem_req    = 1'b0;
  assign mem_addr_o = 8'h00;
  assign mem_wdata  = 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_done <= 1'b0;
    end else begin
      wb_done <= accept;
    end
  end

  logic unused_mem_inputs;
  assign unused_mem_inputs = ^{mem_addr, mem_ack};
`endif

endmodule

// File: tb/tb_alu_writeback.sv
`timescale 1ns/1ps
module tb_alu_writeback;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] res_l, res_h;
  logic       carry_in, zero_in, sign_in;
  logic [2:0] flag_mask;
  logic [1:0] dest;
  logic [7:0] mem_addr;
  logic       mem_req;
  logic [7:0] mem_addr_o, mem_wdata;
  logic       mem_ack;
  logic [7:0] w_reg, h_reg;
  logic [2:0] flags;
  logic       cpu_carry;
  logic       wb_done;

  always #5 clk = ~clk;

  alu_writeback dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .res_l      (res_l),
    .res_h      (res_h),
    .carry_in   (carry_in),
    .zero_in    (zero_in),
    .sign_in    (sign_in),
    .flag_mask  (flag_mask),
    .dest       (dest),
    .mem_addr   (mem_addr),
    .mem_req    (mem_req),
    .mem_addr_o (mem_addr_o),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .w_reg      (w_reg),
    .h_reg      (h_reg),
    .flags      (flags),
    .cpu_carry  (cpu_carry),
    .wb_done    (wb_done)
  );

  typedef struct packed {
    logic [7:0] w;
    logic [7:0] h;
    logic [2:0] f;
  } wb_exp_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_exp_t;

  wb_exp_t wb_q[$];
  wr_exp_t wr_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int ack_delay = 0;
  bit mem_req_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Memory responder: acks after ack_delay waiting cycles, one-cycle ack pulse
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    mem_ack  = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack  = 1'b1;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboards whenever the DUT presents a completion or a write
  initial begin
    wb_exp_t    e;
    wr_exp_t    m;
    bit         held;
    logic [7:0] prev_a, prev_d;
    held = 1'b0;
    prev_a = 8'h00;
    prev_d = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_req) mem_req_seen = 1'b1;
      if (rst_n && wb_done) begin
        if (wb_q.size() == 0) begin
          chk("wb_done_unexpected", {31'd0, wb_done}, 32'd0);
        end else begin
          e = wb_q.pop_front();
          chk("w_reg", {24'd0, w_reg}, {24'd0, e.w});
          chk("h_reg", {24'd0, h_reg}, {24'd0, e.h});
          chk("flags", {29'd0, flags}, {29'd0, e.f});
          chk("cpu_carry", {31'd0, cpu_carry}, {31'd0, e.f[0]});
        end
      end
      if (rst_n && mem_req) begin
        chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
        if (held) begin
          chk("mem_addr_stable", {24'd0, mem_addr_o}, {24'd0, prev_a});
          chk("mem_wdata_stable", {24'd0, mem_wdata}, {24'd0, prev_d});
        end
        if (mem_ack) begin
          if (wr_q.size() == 0) begin
            chk("mem_write_unexpected", {31'd0, mem_ack}, 32'd0);
          end else begin
            m = wr_q.pop_front();
            chk("mem_addr_o", {24'd0, mem_addr_o}, {24'd0, m.a});
            chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, m.d});
          end
          held = 1'b0;
        end else begin
          held = 1'b1;
        end
        prev_a = mem_addr_o;
        prev_d = mem_wdata;
      end else begin
        held = 1'b0;
      end
    end
  end

  // szc = {sign_in, zero_in, carry_in}; returns #1 after the accept edge with in_valid still high
  task automatic issue(input logic [1:0] d, input logic [7:0] rl, input logic [7:0] rh,
                       input logic [7:0] a, input logic [2:0] szc, input logic [2:0] m,
                       input logic [7:0] ew, input logic [7:0] eh, input logic [2:0] ef,
                       input bit push);
    @(negedge clk);
    dest      = d;
    res_l     = rl;
    res_h     = rh;
    mem_addr  = a;
    sign_in   = szc[2];
    zero_in   = szc[1];
    carry_in  = szc[0];
    flag_mask = m;
    in_valid  = 1'b1;
    for (int i = 0; i < 200 && !in_ready; i++) @(negedge clk);
    if (!in_ready) begin
      chk("accept_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
    end else begin
      if (push) wb_q.push_back('{w: ew, h: eh, f: ef});
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (wb_q.size() != 0 || wr_q.size() != 0); i++) @(negedge clk);
    chk("wb_queue_drained", wb_q.size(), 32'd0);
    chk("wr_queue_drained", wr_q.size(), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_w"}, {24'd0, w_reg}, 32'h00);
    chk({tag, "_h"}, {24'd0, h_reg}, 32'h00);
    chk({tag, "_flags"}, {29'd0, flags}, 32'd0);
    chk({tag, "_cpu_carry"}, {31'd0, cpu_carry}, 32'd0);
    chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_mem_addr_o"}, {24'd0, mem_addr_o}, 32'h00);
    chk({tag, "_mem_wdata"}, {24'd0, mem_wdata}, 32'h00);
    chk({tag, "_wb_done"}, {31'd0, wb_done}, 32'd0);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    res_l = 8'h00;
    res_h = 8'h00;
    carry_in = 1'b0;
    zero_in = 1'b0;
    sign_in = 1'b0;
    flag_mask = 3'b000;
    dest = 2'b00;
    mem_addr = 8'h00;

    #3;
    chk_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

    // dest=00, all flags loaded
    issue(2'b00, 8'h5A, 8'hEE, 8'h00, 3'b001, 3'b111, 8'h5A, 8'h00, 3'b001, 1'b1);
    idle();
    chk("wb_done_one_cycle_after", {31'd0, wb_done}, 32'd1);
    @(posedge clk);
    #1;
    chk("wb_done_single_pulse", {31'd0, wb_done}, 32'd0);

    // dest=01, only Z loads
    issue(2'b01, 8'h34, 8'h12, 8'h00, 3'b110, 3'b010, 8'h34, 8'h12, 3'b011, 1'b1);
    idle();
    drain();

    // back-to-back register writes, one per cycle
    issue(2'b00, 8'h01, 8'h00, 8'h00, 3'b000, 3'b001, 8'h01, 8'h12, 3'b010, 1'b1);
    issue(2'b01, 8'h02, 8'h03, 8'h00, 3'b100, 3'b100, 8'h02, 8'h03, 3'b110, 1'b1);
    issue(2'b00, 8'hFF, 8'h44, 8'h00, 3'b011, 3'b000, 8'hFF, 8'h03, 3'b110, 1'b1);
    idle();
    drain();

`ifdef ALU_WB_MEM_EN
    // two-byte write at 0xFF with a slow memory: address wraps to 0x00
    ack_delay = 3;
    wr_q.push_back('{a: 8'hFF, d: 8'hAA});
    wr_q.push_back('{a: 8'h00, d: 8'hBB});
    issue(2'b11, 8'hAA, 8'hBB, 8'hFF, 3'b000, 3'b000, 8'hFF, 8'h03, 3'b110, 1'b1);
    idle();
    drain();

    // single-byte write with a second result held valid behind it
    ack_delay = 2;
    wr_q.push_back('{a: 8'h40, d: 8'h11});
    issue(2'b10, 8'h11, 8'h22, 8'h40, 3'b000, 3'b000, 8'hFF, 8'h03, 3'b110, 1'b1);
    chk("in_ready_mem_lo", {31'd0, in_ready}, 32'd0);
    issue(2'b00, 8'h99, 8'h00, 8'h00, 3'b001, 3'b001, 8'h99, 8'h03, 3'b111, 1'b1);
    idle();
    drain();

    // reset asserted while the high byte is pending
    ack_delay = 0;
    wr_q.push_back('{a: 8'h10, d: 8'h01});
    issue(2'b11, 8'h01, 8'h02, 8'h10, 3'b111, 3'b111, 8'h00, 8'h00, 3'b000, 1'b0);
    idle();
    for (int i = 0; i < 50 && !(mem_req && mem_addr_o == 8'h11); i++) @(negedge clk);
    chk("reached_mem_hi", {24'd0, mem_addr_o}, 32'h11);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mem_req_seen = 1'b0;
    repeat (10) @(negedge clk);
    chk("no_retry_after_abort", {31'd0, mem_req_seen}, 32'd0);
    chk("wr_queue_after_abort", wr_q.size(), 32'd0);
`else
    // memory destinations only touch flags and complete immediately
    issue(2'b10, 8'h77, 8'h66, 8'h30, 3'b001, 3'b001, 8'hFF, 8'h03, 3'b111, 1'b1);
    chk("in_ready_stays_idle", {31'd0, in_ready}, 32'd1);
    chk("wb_done_mem_disabled", {31'd0, wb_done}, 32'd1);
    issue(2'b11, 8'h55, 8'h66, 8'h31, 3'b000, 3'b110, 8'hFF, 8'h03, 3'b001, 1'b1);
    idle();
    drain();
    chk("mem_req_never", {31'd0, mem_req_seen}, 32'd0);
    chk("mem_addr_o_tied", {24'd0, mem_addr_o}, 32'h00);
    chk("mem_wdata_tied", {24'd0, mem_wdata}, 32'h00);
`endif

    // asynchronous reset right after an accept cancels the pending completion
    issue(2'b01, 8'h12, 8'h34, 8'h00, 3'b111, 3'b111, 8'h00, 8'h00, 3'b000, 1'b0);
    idle();
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async");
    @(negedge clk);
    chk("wb_queue_final", wb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
